// File: rtl/cnt_ctrl_pkg.sv
// Shared types and helpers for the BCD stopwatch counter controller.
// Holds the FSM state encoding, digit width and single-digit BCD increment.
package cnt_ctrl_pkg;

  localparam int BCD_W      = 4;
  localparam int DIGITS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // One BCD digit plus carry-in; returns {carry_out, digit}.
  function automatic logic [BCD_W:0] digit_inc(input logic [BCD_W-1:0] d,
                                               input logic             cin);
    logic [BCD_W:0] r;
    r = {1'b0, d};
    if (cin) begin
      if (d == BCD_W'(9)) r = {1'b1, {BCD_W{1'b0}}};
      else                r = {1'b0, d + BCD_W'(1)};
    end
    return r;
  endfunction

endpackage

// File: rtl/cnt_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, tick_scan-sampled debounce, rising-edge pulse.
// A button must be seen released after reset before any press is reported.
module btn_debounce
  import cnt_ctrl_pkg::*;
#(
  parameter int DEB_SAMPLES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic tick_scan_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEB_SAMPLES + 1);

  logic [1:0]             sync_q;
  logic [DEB_SAMPLES-1:0] samp_q, samp_d;
  logic [DEB_SAMPLES:0]   samp_ext;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q, armed_q, press_q;
  logic                   full, all1, all0;

  // Window of the newest DEB_SAMPLES samples, including the one taken this tick.
  always_comb begin
    samp_ext = {samp_q, sync_q[1]};
    samp_d   = samp_ext[DEB_SAMPLES-1:0];
    full     = (cnt_q >= CNT_W'(DEB_SAMPLES - 1));
    all1     = full & (&samp_d);
    all0     = full & ~(|samp_d);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      samp_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      press_q <= 1'b0;
      if (tick_scan_i) begin
        samp_q <= samp_d;
        if (cnt_q != CNT_W'(DEB_SAMPLES)) cnt_q <= cnt_q + CNT_W'(1);
        if (all1) begin
          level_q <= 1'b1;
          press_q <= ~level_q & armed_q;
        end
        // Arming needs a genuine post-reset low window, so a held button stays silent.
        if (all0) begin
          level_q <= 1'b0;
          armed_q <= 1'b1;
        end
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/cnt_ctrl.sv
// Stopwatch controller: debounced start/stop/clear buttons drive an IDLE/RUN/PAUSE FSM
// that gates a DIGITS-wide BCD seconds counter, plus a multiplexed digit scanner.
module cnt_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int DIGITS      = DIGITS_DEF,
  parameter int DEB_SAMPLES = 2
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic                      tick_sec,
  input  logic                      tick_scan,
  input  logic                      btn_start,
  input  logic                      btn_stop,
  input  logic                      btn_clr,
  output logic [BCD_W*DIGITS-1:0]   bcd,
  output logic [BCD_W-1:0]          dig_val,
  output logic [DIGITS-1:0]         an,
  output logic                      running,
  output logic                      ovf
);

  localparam int SCAN_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic start_p, stop_p, clr_p;

  btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_start (
    .clk_in(clk_in), .rst(rst), .tick_scan_i(tick_scan), .btn_i(btn_start), .press_o(start_p)
  );
  btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_stop (
    .clk_in(clk_in), .rst(rst), .tick_scan_i(tick_scan), .btn_i(btn_stop), .press_o(stop_p)
  );
  btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_clr (
    .clk_in(clk_in), .rst(rst), .tick_scan_i(tick_scan), .btn_i(btn_clr), .press_o(clr_p)
  );

  state_t                        state_q;
  logic                          running_q, ovf_q;
  logic [DIGITS-1:0][BCD_W-1:0]  bcd_q, bcd_d;
  logic                          carry;
  logic [BCD_W:0]                dres;

  // Ripple-carry decimal increment; carry out of the top digit means all-9s wrapped.
  always_comb begin
    bcd_d = bcd_q;
    carry = 1'b1;
    dres  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dres     = digit_inc(bcd_q[i], carry);
      bcd_d[i] = dres[BCD_W-1:0];
      carry    = dres[BCD_W];
    end
  end

  // Press priority clr > stop > start: a higher pulse suppresses the lower ones.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (clr_p) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (state_q == RUN && tick_sec) begin
        bcd_q <= bcd_d;
        if (carry) ovf_q <= 1'b1;
      end
      case (state_q)
        IDLE, PAUSE: if (!stop_p && start_p) begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        RUN: if (stop_p) begin
          state_q   <= PAUSE;
          running_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  logic [SCAN_W-1:0] idx_q;
  logic [DIGITS-1:0] an_q;
  logic [BCD_W-1:0]  dig_val_q;

  // Each tick shows the current index, then advances it.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      an_q      <= '1;
      dig_val_q <= '0;
    end else if (tick_scan) begin
      an_q      <= ~(DIGITS'(1) << idx_q);
      dig_val_q <= bcd_q[idx_q];
      idx_q     <= (idx_q == SCAN_W'(DIGITS - 1)) ? '0 : idx_q + SCAN_W'(1);
    end
  end

  assign bcd     = bcd_q;
  assign dig_val = dig_val_q;
  assign an      = an_q;
  assign running = running_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_cnt_ctrl.sv
// Self-checking bench for cnt_ctrl: scenario tasks plus a randomized operation mix,
// all checked against an integer-count stopwatch model.
module tb_cnt_ctrl;

  localparam int DIGITS = 4;
  localparam int DEB    = 2;
  localparam int B_START = 0, B_STOP = 1, B_CLR = 2;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2;

  logic clk_in = 1'b0;
  logic rst, tick_sec, tick_scan, btn_start, btn_stop, btn_clr;
  logic [4*DIGITS-1:0] bcd;
  logic [3:0]          dig_val;
  logic [DIGITS-1:0]   an;
  logic                running, ovf;

  int n_chk = 0, n_fail = 0;
  int m_cnt, m_st, m_nscan;
  bit m_ovf;

  always #5 clk_in = ~clk_in;

  cnt_ctrl #(.DIGITS(DIGITS), .DEB_SAMPLES(DEB)) dut (
    .clk_in(clk_in), .rst(rst), .tick_sec(tick_sec), .tick_scan(tick_scan),
    .btn_start(btn_start), .btn_stop(btn_stop), .btn_clr(btn_clr),
    .bcd(bcd), .dig_val(dig_val), .an(an), .running(running), .ovf(ovf)
  );

  // ---------------- reference model ----------------
  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r = '0;
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] exp_an(input int nscan);
    logic [DIGITS-1:0] one = 1;
    if (nscan == 0) return '1;
    return ~(one << ((nscan - 1) % DIGITS));
  endfunction

  function automatic logic [3:0] exp_dig(input int nscan, input int cnt);
    if (nscan == 0) return 4'd0;
    return 4'((cnt / pow10((nscan - 1) % DIGITS)) % 10);
  endfunction

  task automatic m_reset();
    m_cnt = 0; m_ovf = 0; m_st = S_IDLE; m_nscan = 0;
  endtask

  task automatic m_sec();
    if (m_st == S_RUN) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == pow10(DIGITS)) begin m_cnt = 0; m_ovf = 1; end
    end
  endtask

  task automatic m_press(input int b);
    case (b)
      B_CLR:   begin m_st = S_IDLE; m_cnt = 0; m_ovf = 0; end
      B_STOP:  if (m_st == S_RUN) m_st = S_PAUSE;
      default: if (m_st != S_RUN) m_st = S_RUN;
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_START: btn_start = v;
      B_STOP:  btn_stop  = v;
      default: btn_clr   = v;
    endcase
  endtask

  task automatic scan_tick();
    @(negedge clk_in) tick_scan = 1'b1;
    @(negedge clk_in) tick_scan = 1'b0;
    m_nscan++;
  endtask

  task automatic sec_hold(input int n);
    @(negedge clk_in) tick_sec = 1'b1;
    repeat (n - 1) @(negedge clk_in);
    @(negedge clk_in) tick_sec = 1'b0;
    repeat (n) m_sec();
  endtask

  // Debounced press; with coincide, tick_sec lands on the press-pulse cycle.
  task automatic btn_down(input int b, input bit coincide);
    set_btn(b, 1'b1);
    cyc(3);
    for (int i = 0; i < DEB - 1; i++) scan_tick();
    @(negedge clk_in) tick_scan = 1'b1;
    @(negedge clk_in) begin tick_scan = 1'b0; tick_sec = coincide; end
    @(negedge clk_in) tick_sec = 1'b0;
    m_nscan++;
    if (coincide && b != B_CLR) m_sec();
    m_press(b);
  endtask

  task automatic btn_up(input int b);
    set_btn(b, 1'b0);
    cyc(3);
    for (int i = 0; i < DEB; i++) scan_tick();
    cyc(2);
  endtask

  task automatic press(input int b);
    btn_down(b, 1'b0);
    btn_up(b);
  endtask

  task automatic glitch(input int b);
    set_btn(b, 1'b1);
    cyc(3);
    scan_tick();
    set_btn(b, 1'b0);
    cyc(3);
    for (int i = 0; i < DEB; i++) scan_tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; tick_sec = 0; tick_scan = 0; btn_start = 0; btn_stop = 0; btn_clr = 0;
    m_reset();
    cyc(3);
    n_chk++; if (bcd !== '0)     begin n_fail++; $display("FAIL rst_bcd: got %h want 0", bcd); end
    n_chk++; if (an !== '1)      begin n_fail++; $display("FAIL rst_an: got %b want 1111", an); end
    n_chk++; if (running !== 0 || ovf !== 0 || dig_val !== 0)
      begin n_fail++; $display("FAIL rst_flags: run %b ovf %b dig %h want 0 0 0", running, ovf, dig_val); end
    @(negedge clk_in) rst = 1'b0;
    cyc(4);
    n_chk++; if (an !== '1)      begin n_fail++; $display("FAIL post_rst_an: got %b want 1111", an); end
  endtask

  task automatic test_scan();
    logic [DIGITS-1:0] seq [5];
    seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    for (int i = 0; i < 5; i++) begin
      scan_tick();
      n_chk++; if (an !== seq[i] || dig_val !== 4'd0)
        begin n_fail++; $display("FAIL scan_seq%0d: an %b dig %h want %b 0", i, an, dig_val, seq[i]); end
    end
  endtask

  task automatic test_debounce();
    press(B_START);
    sec_hold(1); sec_hold(1); sec_hold(1);
    n_chk++; if (bcd !== 16'h0003 || running !== 1'b1)
      begin n_fail++; $display("FAIL deb_start: bcd %h run %b want 0003 1", bcd, running); end
    glitch(B_STOP);
    sec_hold(1);
    n_chk++; if (bcd !== 16'h0004 || running !== 1'b1)
      begin n_fail++; $display("FAIL deb_glitch: bcd %h run %b want 0004 1", bcd, running); end
  endtask

  task automatic test_pause_resume();
    logic [4*DIGITS-1:0] held;
    press(B_STOP);
    held = to_bcd(m_cnt);
    repeat (5) sec_hold(1);
    n_chk++; if (bcd !== held || running !== 1'b0)
      begin n_fail++; $display("FAIL pause: bcd %h run %b want %h 0", bcd, running, held); end
    press(B_START);
    repeat (2) sec_hold(1);
    n_chk++; if (bcd !== to_bcd(m_cnt) || running !== 1'b1)
      begin n_fail++; $display("FAIL resume: bcd %h run %b want %h 1", bcd, running, to_bcd(m_cnt)); end
  endtask

  task automatic test_hold();
    btn_down(B_START, 1'b0);
    press(B_STOP);
    repeat (6) scan_tick();
    n_chk++; if (running !== 1'b0)
      begin n_fail++; $display("FAIL hold_norepeat: run %b want 0", running); end
    btn_up(B_START);
    press(B_START);
    n_chk++; if (running !== 1'b1)
      begin n_fail++; $display("FAIL hold_repress: run %b want 1", running); end
  endtask

  task automatic test_collision();
    press(B_CLR); press(B_START);
    sec_hold(42);
    n_chk++; if (bcd !== 16'h0042) begin n_fail++; $display("FAIL coll_pre: bcd %h want 0042", bcd); end
    btn_down(B_CLR, 1'b1);
    n_chk++; if (bcd !== 16'h0000 || ovf !== 1'b0 || running !== 1'b0)
      begin n_fail++; $display("FAIL coll_clr: bcd %h ovf %b run %b want 0000 0 0", bcd, ovf, running); end
    btn_up(B_CLR);
    press(B_START);
    sec_hold(5);
    btn_down(B_STOP, 1'b1);
    n_chk++; if (bcd !== 16'h0006 || running !== 1'b0)
      begin n_fail++; $display("FAIL coll_stop: bcd %h run %b want 0006 0", bcd, running); end
    btn_up(B_STOP);
  endtask

  task automatic test_wrap();
    press(B_CLR); press(B_START);
    sec_hold(pow10(DIGITS) - 1);
    n_chk++; if (bcd !== 16'h9999 || ovf !== 1'b0)
      begin n_fail++; $display("FAIL wrap_pre: bcd %h ovf %b want 9999 0", bcd, ovf); end
    sec_hold(1);
    n_chk++; if (bcd !== 16'h0000 || ovf !== 1'b1 || running !== 1'b1)
      begin n_fail++; $display("FAIL wrap: bcd %h ovf %b run %b want 0000 1 1", bcd, ovf, running); end
    sec_hold(1);
    n_chk++; if (bcd !== 16'h0001 || ovf !== 1'b1)
      begin n_fail++; $display("FAIL wrap_sticky: bcd %h ovf %b want 0001 1", bcd, ovf); end
    press(B_CLR);
    n_chk++; if (ovf !== 1'b0 || bcd !== 16'h0000)
      begin n_fail++; $display("FAIL wrap_clr: bcd %h ovf %b want 0000 0", bcd, ovf); end
  endtask

  task automatic test_random();
    int op, b, n;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1, 2: begin
          b = op;
          btn_down(b, 1'($urandom_range(0, 1)));
          btn_up(b);
        end
        3: sec_hold($urandom_range(1, 30));
        4: glitch($urandom_range(0, 2));
        default: begin
          n = $urandom_range(1, 6);
          for (int k = 0; k < n; k++) begin
            scan_tick();
            n_chk++; if (an !== exp_an(m_nscan) || dig_val !== exp_dig(m_nscan, m_cnt))
              begin n_fail++; $display("FAIL rnd_scan it%0d: an %b dig %h want %b %h", it, an, dig_val,
                                       exp_an(m_nscan), exp_dig(m_nscan, m_cnt)); end
          end
        end
      endcase
      n_chk++; if (bcd !== to_bcd(m_cnt) || running !== (m_st == S_RUN) || ovf !== m_ovf)
        begin n_fail++; $display("FAIL rnd it%0d op%0d: bcd %h run %b ovf %b want %h %b %b", it, op,
                                 bcd, running, ovf, to_bcd(m_cnt), m_st == S_RUN, m_ovf); end
    end
  endtask

  task automatic test_reset_midrun();
    press(B_CLR); press(B_START);
    sec_hold(17);
    n_chk++; if (bcd !== 16'h0017) begin n_fail++; $display("FAIL mid_pre: bcd %h want 0017", bcd); end
    @(negedge clk_in) btn_start = 1'b1;
    @(negedge clk_in);
    #2 rst = 1'b1;
    #1;
    n_chk++; if (bcd !== '0 || an !== '1 || running !== 1'b0)
      begin n_fail++; $display("FAIL mid_rst: bcd %h an %b run %b want 0000 1111 0", bcd, an, running); end
    @(negedge clk_in) rst = 1'b0;
    m_reset();
    cyc(3);
    repeat (4) scan_tick();
    n_chk++; if (running !== 1'b0)
      begin n_fail++; $display("FAIL mid_held: run %b want 0", running); end
    btn_up(B_START);
    press(B_START);
    n_chk++; if (running !== 1'b1)
      begin n_fail++; $display("FAIL mid_repress: run %b want 1", running); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_debounce();
    test_pause_resume();
    test_hold();
    test_collision();
    test_wrap();
    test_random();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
